// File: rtl/reducao_media.sv
// 2x downscaler: averages each 2x2 block of the source frame with rounding and
// writes the (LARGURA/2)x(ALTURA/2) result to the destination RAM in raster order.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OCIOSO  | idle, waiting for executar
// LEITURA | issuing the four block reads, k = 0..3
// ESPERA  | two cycles draining the RAM read latency, k = 0..1
// ESCRITA | writing the rounded average, advancing x/y
// FIM     | one-cycle pronto pulse
module reducao_media #(
    parameter int LARGURA  = 320,
    parameter int ALTURA   = 240,
    parameter int BITS_END = 17
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                executar,
    output logic                ocupado,
    output logic                pronto,
    output logic [BITS_END-1:0] end_leitura,
    output logic                rden,
    input  logic [7:0]          pixel_entrada,
    output logic [BITS_END-1:0] end_escrita,
    output logic                wren,
    output logic [7:0]          pixel_saida
);

    localparam int MEIA_L = LARGURA / 2;
    localparam int MEIA_A = ALTURA / 2;
    localparam int XW     = (MEIA_L > 1) ? $clog2(MEIA_L) : 1;
    localparam int YW     = (MEIA_A > 1) ? $clog2(MEIA_A) : 1;

    localparam logic [XW-1:0]       X_MAX    = XW'(MEIA_L - 1);
    localparam logic [YW-1:0]       Y_MAX    = YW'(MEIA_A - 1);
    localparam logic [BITS_END-1:0] LARG_E   = BITS_END'(LARGURA);
    localparam logic [BITS_END-1:0] MEIA_L_E = BITS_END'(MEIA_L);

    typedef enum logic [2:0] {
        OCIOSO,
        LEITURA,
        ESPERA,
        ESCRITA,
        FIM
    } estado_t;

    estado_t             estado, estado_n;
    logic [1:0]          k, k_n;
    logic [XW-1:0]       x, x_n;
    logic [YW-1:0]       y, y_n;
    logic [9:0]          soma, soma_n;
    logic                rden_d1, rden_d2;

    logic                ocupado_n, pronto_n, rden_n, wren_n;
    logic [BITS_END-1:0] end_leitura_n, end_escrita_n;
    logic [7:0]          pixel_saida_n;
    logic [BITS_END-1:0] linha, coluna;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado      <= OCIOSO;
            k           <= '0;
            x           <= '0;
            y           <= '0;
            soma        <= '0;
            rden_d1     <= 1'b0;
            rden_d2     <= 1'b0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
            rden        <= 1'b0;
            wren        <= 1'b0;
            end_leitura <= '0;
            end_escrita <= '0;
            pixel_saida <= '0;
        end else begin
            estado      <= estado_n;
            k           <= k_n;
            x           <= x_n;
            y           <= y_n;
            soma        <= soma_n;
            rden_d1     <= rden;
            rden_d2     <= rden_d1;
            ocupado     <= ocupado_n;
            pronto      <= pronto_n;
            rden        <= rden_n;
            wren        <= wren_n;
            end_leitura <= end_leitura_n;
            end_escrita <= end_escrita_n;
            pixel_saida <= pixel_saida_n;
        end
    end

    // rden delayed by the two-cycle RAM latency marks when pixel_entrada holds block data
    always_comb begin
        estado_n = estado;
        k_n      = k;
        x_n      = x;
        y_n      = y;
        soma_n   = rden_d2 ? (soma + {2'b00, pixel_entrada}) : soma;

        case (estado)
            OCIOSO: begin
                if (executar) begin
                    estado_n = LEITURA;
                    k_n      = '0;
                    x_n      = '0;
                    y_n      = '0;
                    soma_n   = '0;
                end
            end
            LEITURA: begin
                if (k == 2'd3) begin
                    estado_n = ESPERA;
                    k_n      = '0;
                end else begin
                    k_n = k + 2'd1;
                end
            end
            ESPERA: begin
                if (k == 2'd1) begin
                    estado_n = ESCRITA;
                    k_n      = '0;
                end else begin
                    k_n = k + 2'd1;
                end
            end
            ESCRITA: begin
                soma_n = '0;
                k_n    = '0;
                if (x == X_MAX) begin
                    x_n = '0;
                    y_n = (y == Y_MAX) ? '0 : y + 1'b1;
                end else begin
                    x_n = x + 1'b1;
                end
                estado_n = ((x == X_MAX) && (y == Y_MAX)) ? FIM : LEITURA;
            end
            FIM: begin
                estado_n = OCIOSO;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

    // Outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        linha  = (BITS_END'(y_n) << 1) + BITS_END'(k_n[1]);
        coluna = (BITS_END'(x_n) << 1) + BITS_END'(k_n[0]);

        ocupado_n     = (estado_n != OCIOSO);
        pronto_n      = (estado_n == FIM);
        rden_n        = (estado_n == LEITURA);
        wren_n        = (estado_n == ESCRITA);
        end_leitura_n = '0;
        end_escrita_n = '0;
        pixel_saida_n = '0;

        if (rden_n) begin
            end_leitura_n = linha * LARG_E + coluna;
        end
        // soma_n already includes the fourth sample arriving on this edge
        if (wren_n) begin
            end_escrita_n = BITS_END'(y_n) * MEIA_L_E + BITS_END'(x_n);
            pixel_saida_n = 8'((soma_n + 10'd2) >> 2);
        end
    end

endmodule
